// File: rtl/if_stage_if.sv
// Handshake and bus bundle between pre-IF/ICache/ID and the IF stage.
// The slave modport is the IF stage; the master is the surrounding pipeline.
interface if_stage_if;
  logic        ps_to_fs_valid;
  logic [39:0] ps_to_fs_bus;
  logic        fs_allowin;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [69:0] fs_to_ds_bus;
  logic        flush;

  modport slave (
    input  ps_to_fs_valid, ps_to_fs_bus, inst_rdata, inst_data_ok, ds_allowin, flush,
    output fs_allowin, fs_to_ds_valid, fs_to_ds_bus
  );

  modport master (
    output ps_to_fs_valid, ps_to_fs_bus, inst_rdata, inst_data_ok, ds_allowin, flush,
    input  fs_allowin, fs_to_ds_valid, fs_to_ds_bus
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: tracks one outstanding ICache request per entry and
// hands the fetched word (or a fetch exception) to ID, with zero-latency bypass.
module if_stage (
  input  logic      clk,
  input  logic      resetn,
  if_stage_if.slave fs
);
  typedef enum logic [1:0] {EMPTY, WAIT, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        ex_q, ex_d;
  logic [4:0]  exctype_q, exctype_d;

  logic        in_inst_valid, in_bdd, in_ex;
  logic [31:0] in_pc;
  logic [4:0]  in_exctype;
  logic        fs_ready_go, allowin, capture, accept, handoff, bypass;
  state_t      cap_state;

  assign {in_inst_valid, in_bdd, in_pc, in_ex, in_exctype} = fs.ps_to_fs_bus;

  always_comb begin
    fs_ready_go = (state_q == HOLD) || ((state_q == WAIT) && fs.inst_data_ok);
    allowin     = fs.flush || (state_q == EMPTY)
                || (((state_q == WAIT) || (state_q == HOLD)) && fs_ready_go && fs.ds_allowin)
                || ((state_q == DROP) && fs.inst_data_ok);
    capture     = fs.ps_to_fs_valid && allowin && !fs.flush;
    accept      = capture && (in_inst_valid || in_ex);
    cap_state   = in_ex ? HOLD : (in_bdd ? DROP : WAIT);
    handoff     = fs_ready_go && !fs.flush && fs.ds_allowin;
    bypass      = (state_q == WAIT) && fs.inst_data_ok;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    ex_d       = ex_q;
    exctype_d  = exctype_q;
    unique case (state_q)
      EMPTY: state_d = EMPTY;
      WAIT: begin
        // A flush coinciding with data_ok completes the request; going to DROP would wait forever.
        if (fs.flush)
          state_d = fs.inst_data_ok ? EMPTY : DROP;
        else if (fs.inst_data_ok && !fs.ds_allowin) begin
          state_d    = HOLD;
          inst_buf_d = fs.inst_rdata;
        end else if (handoff)
          state_d = EMPTY;
      end
      HOLD: if (fs.flush || handoff) state_d = EMPTY;
      DROP: if (fs.inst_data_ok) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // Capture only occurs in cycles where the current occupant has just left.
    if (accept) begin
      state_d    = cap_state;
      pc_d       = in_pc;
      ex_d       = in_ex;
      exctype_d  = in_exctype;
      inst_buf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= EMPTY;
      pc_q       <= '0;
      inst_buf_q <= '0;
      ex_q       <= 1'b0;
      exctype_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      ex_q       <= ex_d;
      exctype_q  <= exctype_d;
    end
  end

  assign fs.fs_allowin     = allowin;
  assign fs.fs_to_ds_valid = fs_ready_go && !fs.flush;
  assign fs.fs_to_ds_bus   = {ex_q, exctype_q, pc_q, bypass ? fs.inst_rdata : inst_buf_q};
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes expected ID-bound words into a
// queue, a negedge monitor pops and compares on every handoff to ID.
module tb_if_stage;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  if_stage_if ifc ();
  if_stage dut (.clk(clk), .resetn(resetn), .fs(ifc));

  int checks = 0;
  int errors = 0;
  logic [69:0] exp_q[$];
  logic [69:0] mon_exp;

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [39:0] ps(input logic iv, input logic bdd, input logic [31:0] pc,
                                     input logic ex, input logic [4:0] et);
    return {iv, bdd, pc, ex, et};
  endfunction

  function automatic logic [69:0] ds(input logic ex, input logic [4:0] et,
                                     input logic [31:0] pc, input logic [31:0] inst);
    return {ex, et, pc, inst};
  endfunction

  task automatic drive(input logic pv, input logic [39:0] pb, input logic dok,
                       input logic [31:0] rd, input logic dsa, input logic fl);
    ifc.ps_to_fs_valid = pv;
    ifc.ps_to_fs_bus   = pb;
    ifc.inst_data_ok   = dok;
    ifc.inst_rdata     = rd;
    ifc.ds_allowin     = dsa;
    ifc.flush          = fl;
  endtask

  task automatic idle(input logic dsa);
    drive(1'b0, '0, 1'b0, '0, dsa, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && ifc.fs_to_ds_valid === 1'b1 && ifc.ds_allowin === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got bus %h with valid=1, required no delivery",
                 ifc.fs_to_ds_bus);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("delivery", ifc.fs_to_ds_bus, mon_exp);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle(1'b0);
    #2;
    chk("reset_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("reset_allowin", 70'(ifc.fs_allowin), 70'd1);
    chk("reset_bus", ifc.fs_to_ds_bus, '0);
    step(); step();
    resetn = 1'b1;
    step();

    // Basic fetch with bypass delivery
    drive(1'b1, ps(1'b1, 1'b0, 32'hBFC00000, 1'b0, 5'd0), 1'b0, '0, 1'b1, 1'b0);
    #1 chk("t1_allowin_empty", 70'(ifc.fs_allowin), 70'd1);
    exp_q.push_back(ds(1'b0, 5'd0, 32'hBFC00000, 32'h3C080001));
    step();
    drive(1'b0, '0, 1'b1, 32'h3C080001, 1'b1, 1'b0);
    #1 chk("t1_valid_bypass", 70'(ifc.fs_to_ds_valid), 70'd1);
    step();
    idle(1'b1);
    #1 chk("t1_empty_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("t1_empty_allowin", 70'(ifc.fs_allowin), 70'd1);
    step();

    // ID stalls for 3 cycles, then back-to-back capture of pc+4
    drive(1'b1, ps(1'b1, 1'b0, 32'hBFC00000, 1'b0, 5'd0), 1'b0, '0, 1'b0, 1'b0);
    exp_q.push_back(ds(1'b0, 5'd0, 32'hBFC00000, 32'h3C080001));
    step();
    drive(1'b0, '0, 1'b1, 32'h3C080001, 1'b0, 1'b0);
    #1 chk("t2_allowin_stall0", 70'(ifc.fs_allowin), 70'd0);
    step();
    for (int unsigned i = 0; i < 2; i++) begin
      idle(1'b0);
      #1 chk("t2_hold_allowin", 70'(ifc.fs_allowin), 70'd0);
      chk("t2_hold_valid", 70'(ifc.fs_to_ds_valid), 70'd1);
      chk("t2_hold_inst", 70'(ifc.fs_to_ds_bus[31:0]), 70'h3C080001);
      step();
    end
    drive(1'b1, ps(1'b1, 1'b0, 32'hBFC00004, 1'b0, 5'd0), 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    #1 chk("t2_release_allowin", 70'(ifc.fs_allowin), 70'd1);
    exp_q.push_back(ds(1'b0, 5'd0, 32'hBFC00004, 32'h24080002));
    step();
    drive(1'b0, '0, 1'b1, 32'h24080002, 1'b1, 1'b0);
    #1 chk("t2_next_valid", 70'(ifc.fs_to_ds_valid), 70'd1);
    step();

    // Address-error exception: HOLD with inst=0, no ICache data needed
    drive(1'b1, ps(1'b0, 1'b0, 32'hBFC00002, 1'b1, 5'h04), 1'b0, '0, 1'b0, 1'b0);
    exp_q.push_back(ds(1'b1, 5'h04, 32'hBFC00002, 32'h0));
    step();
    idle(1'b0);
    #1 chk("t3_ex_valid", 70'(ifc.fs_to_ds_valid), 70'd1);
    chk("t3_ex_bus", ifc.fs_to_ds_bus, ds(1'b1, 5'h04, 32'hBFC00002, 32'h0));
    chk("t3_ex_allowin", 70'(ifc.fs_allowin), 70'd0);
    step();
    idle(1'b1);
    step();

    // Branch-delay discard: word fetched but never delivered
    drive(1'b1, ps(1'b1, 1'b1, 32'hBFC00008, 1'b0, 5'd0), 1'b0, '0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    #1 chk("t4_drop_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("t4_drop_allowin", 70'(ifc.fs_allowin), 70'd0);
    step();
    drive(1'b0, '0, 1'b1, 32'h12345678, 1'b1, 1'b0);
    #1 chk("t4_dataok_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("t4_dataok_allowin", 70'(ifc.fs_allowin), 70'd1);
    step();
    idle(1'b1);
    #1 chk("t4_empty_allowin", 70'(ifc.fs_allowin), 70'd1);
    step();

    // Flush in WAIT, data_ok arrives two cycles later, then a fresh entry
    drive(1'b1, ps(1'b1, 1'b0, 32'hBFC0000C, 1'b0, 5'd0), 1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    #1 chk("t5_flush_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("t5_flush_allowin", 70'(ifc.fs_allowin), 70'd1);
    step();
    drive(1'b1, ps(1'b1, 1'b0, 32'hBFC00380, 1'b0, 5'd0), 1'b0, '0, 1'b1, 1'b0);
    #1 chk("t5_drop_allowin", 70'(ifc.fs_allowin), 70'd0);
    chk("t5_drop_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    step();
    drive(1'b1, ps(1'b1, 1'b0, 32'hBFC00380, 1'b0, 5'd0), 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    #1 chk("t5_stale_allowin", 70'(ifc.fs_allowin), 70'd1);
    chk("t5_stale_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    exp_q.push_back(ds(1'b0, 5'd0, 32'hBFC00380, 32'h40806000));
    step();
    drive(1'b0, '0, 1'b1, 32'h40806000, 1'b1, 1'b0);
    #1 chk("t5_new_valid", 70'(ifc.fs_to_ds_valid), 70'd1);
    step();

    // Entry with neither inst_valid nor ex is ignored; stray data_ok in EMPTY too
    drive(1'b1, ps(1'b0, 1'b0, 32'hBFC00020, 1'b0, 5'd0), 1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    #1 chk("t6_ignored_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("t6_ignored_allowin", 70'(ifc.fs_allowin), 70'd1);
    step();

    // Asynchronous reset while holding an exception
    drive(1'b1, ps(1'b0, 1'b0, 32'hBFC00010, 1'b1, 5'h05), 1'b0, '0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    #1 chk("t7_hold_valid", 70'(ifc.fs_to_ds_valid), 70'd1);
    #1 resetn = 1'b0;
    #1 chk("t7_rst_valid", 70'(ifc.fs_to_ds_valid), 70'd0);
    chk("t7_rst_allowin", 70'(ifc.fs_allowin), 70'd1);
    chk("t7_rst_bus", ifc.fs_to_ds_bus, '0);
    step(); step();
    resetn = 1'b1;
    step();

    chk("scoreboard_drained", 70'(exp_q.size()), 70'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
